// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: constants and helpers shared by the ID operand stage.
//   - cmov_e        : conditional-move encodings carried on dec_cmov_i
//   - ZERO_WORD, WRITE_ENABLE/WRITE_DISABLE, NOP_REG_ADDR
//   - aluop/alusel code points used by the decoder and the bench
//   - cmov_we()     : write-enable qualifier for MOVN/MOVZ
package id_operand_stage_pkg;

  typedef enum logic [1:0] {
    CMOV_NONE = 2'b00,
    CMOV_MOVN = 2'b01,
    CMOV_MOVZ = 2'b10,
    CMOV_RSVD = 2'b11
  } cmov_e;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

  localparam logic [7:0]  EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [7:0]  EXE_AND_OP    = 8'b0010_0100;
  localparam logic [7:0]  EXE_OR_OP     = 8'b0010_0101;
  localparam logic [7:0]  EXE_MOVZ_OP   = 8'b0000_1010;
  localparam logic [7:0]  EXE_MOVN_OP   = 8'b0000_1011;

  localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
  localparam logic [2:0]  EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0]  EXE_RES_MOVE  = 3'b011;

  // Reserved encoding behaves like a plain (unconditional) write.
  function automatic logic cmov_we(input logic [1:0] cmov, input logic op2_zero);
    case (cmov_e'(cmov))
      CMOV_MOVN: return !op2_zero;
      CMOV_MOVZ: return op2_zero;
      default:   return WRITE_ENABLE;
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: resolves one source operand.
//   rd_en/addr  : operand read enable and source register
//   imm         : value used when the operand is not a register read
//   rf_data     : regfile read data
//   fwd_*       : N_FWD forwarding channels, index 0 is the youngest stage
//   val         : resolved operand
//   hazard      : matching channel still waiting on load data
module id_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int N_FWD  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                           rd_en,
  input  logic [REG_AW-1:0]              addr,
  input  logic [DATA_W-1:0]              imm,
  input  logic [DATA_W-1:0]              rf_data,
  input  logic [N_FWD-1:0]               fwd_wreg,
  input  logic [N_FWD-1:0][REG_AW-1:0]   fwd_wd,
  input  logic [N_FWD-1:0][DATA_W-1:0]   fwd_wdata,
  input  logic [N_FWD-1:0]               fwd_rdy,
  output logic [DATA_W-1:0]              val,
  output logic                           hazard
);

  logic hit;

  // First match scanning from the youngest channel wins; r0 is never forwarded.
  always_comb begin
    val    = rf_data;
    hazard = 1'b0;
    hit    = 1'b0;
    if (!rd_en) begin
      val = imm;
    end else if (addr == REG_AW'(NOP_REG_ADDR)) begin
      val = DATA_W'(ZERO_WORD);
    end else begin
      for (int i = 0; i < N_FWD; i++) begin
        if (!hit && fwd_wreg[i] && fwd_wd[i] == addr) begin
          hit = 1'b1;
          if (fwd_rdy[i]) val    = fwd_wdata[i];
          else            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-to-execute operand stage with generalised
// forwarding, load-use stall detection, MOVN/MOVZ write-enable resolution
// and the ID/EX register (valid/ready toward EX).
//   clk, rst (async, active-low), flush_i
//   id_valid_i / id_ready_o      : decoder handshake
//   dec_*                        : decoded instruction fields
//   reg1_data_i / reg2_data_i    : regfile read data
//   fwd_wreg/wd/wdata/rdy_i      : N_FWD forwarding channels (0 = EX)
//   ex_ready_i / ex_valid_o      : EX handshake, ex_* registered payload
//   stallreq_o                   : load-use stall request
// Optional macro ID_STALL_CNT_EN adds stall_cnt_o, a saturating count of
// cycles with stallreq_o high.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int N_FWD    = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic                      dec_reg1_read_i,
  input  logic                      dec_reg2_read_i,
  input  logic [REG_AW-1:0]         dec_reg1_addr_i,
  input  logic [REG_AW-1:0]         dec_reg2_addr_i,
  input  logic [DATA_W-1:0]         dec_imm_i,
  input  logic [ALUOP_W-1:0]        dec_aluop_i,
  input  logic [ALUSEL_W-1:0]       dec_alusel_i,
  input  logic [REG_AW-1:0]         dec_wd_i,
  input  logic                      dec_wreg_i,
  input  logic [1:0]                dec_cmov_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [N_FWD-1:0]          fwd_wreg_i,
  input  logic [N_FWD*REG_AW-1:0]   fwd_wd_i,
  input  logic [N_FWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic [N_FWD-1:0]          fwd_rdy_i,
  input  logic                      ex_ready_i,
  output logic                      ex_valid_o,
  output logic [ALUOP_W-1:0]        ex_aluop_o,
  output logic [ALUSEL_W-1:0]       ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [REG_AW-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
`ifdef ID_STALL_CNT_EN
  output logic [31:0]               stall_cnt_o,
`endif
  output logic                      stallreq_o
);

  localparam int NOPS = 2;

  logic [N_FWD-1:0][REG_AW-1:0] fwd_wd;
  logic [N_FWD-1:0][DATA_W-1:0] fwd_wdata;
  logic [NOPS-1:0]              op_rd, op_haz;
  logic [NOPS-1:0][REG_AW-1:0]  op_addr;
  logic [NOPS-1:0][DATA_W-1:0]  op_rf, op_val;
  logic                         hazard, accept, wreg_eff;

  assign fwd_wd    = fwd_wd_i;
  assign fwd_wdata = fwd_wdata_i;
  assign op_rd     = {dec_reg2_read_i, dec_reg1_read_i};
  assign op_addr   = {dec_reg2_addr_i, dec_reg1_addr_i};
  assign op_rf     = {reg2_data_i, reg1_data_i};

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    id_fwd_mux #(.N_FWD(N_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
      .rd_en     (op_rd[g]),
      .addr      (op_addr[g]),
      .imm       (dec_imm_i),
      .rf_data   (op_rf[g]),
      .fwd_wreg  (fwd_wreg_i),
      .fwd_wd    (fwd_wd),
      .fwd_wdata (fwd_wdata),
      .fwd_rdy   (fwd_rdy_i),
      .val       (op_val[g]),
      .hazard    (op_haz[g])
    );
  end

  assign hazard   = |op_haz;
  // MOVN/MOVZ condition uses the forwarded rt, not the stale regfile value.
  assign wreg_eff = dec_wreg_i & cmov_we(dec_cmov_i, op_val[1] == '0);
  assign accept   = id_valid_i && !hazard && (!ex_valid_o || ex_ready_i);

  // Handshake outputs are forced low while reset is held.
  assign id_ready_o = rst && (accept || flush_i);
  assign stallreq_o = rst && id_valid_i && hazard && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o  <= 1'b0;
      ex_aluop_o  <= ALUOP_W'(EXE_NOP_OP);
      ex_alusel_o <= ALUSEL_W'(EXE_RES_NOP);
      ex_reg1_o   <= DATA_W'(ZERO_WORD);
      ex_reg2_o   <= DATA_W'(ZERO_WORD);
      ex_wd_o     <= REG_AW'(NOP_REG_ADDR);
      ex_wreg_o   <= WRITE_DISABLE;
    end else if (flush_i) begin
      ex_valid_o  <= 1'b0;
      ex_wreg_o   <= WRITE_DISABLE;
    end else if (accept) begin
      ex_valid_o  <= 1'b1;
      ex_aluop_o  <= dec_aluop_i;
      ex_alusel_o <= dec_alusel_i;
      ex_reg1_o   <= op_val[0];
      ex_reg2_o   <= op_val[1];
      ex_wd_o     <= dec_wd_i;
      ex_wreg_o   <= wreg_eff;
    end else if (ex_ready_i) begin
      // EX drained the slot and nothing new arrived: insert a bubble.
      ex_valid_o  <= 1'b0;
      ex_wreg_o   <= WRITE_DISABLE;
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              stall_cnt_o <= '0;
    else if (stallreq_o && ~&stall_cnt_o)  stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule
